clkmon: RTL



---
 rtl/clkmon.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/clkmon.sv
// rtl/clkmon.sv - monitored-clock edge pulses, half-period meter and lock/loss FSM
// Optional macro CLKMON_DUTY_EN adds high_period, low_period and duty_err outputs.
`timescale 1ns/1ps
module clkmon #(
    parameter int unsigned sys_clk_freq  = 100000000,
    parameter int unsigned mon_clk_freq  = 25000000,
    parameter int unsigned countlimit    = sys_clk_freq / 2 / mon_clk_freq,
    parameter int unsigned tol           = 0,
    parameter int unsigned lock_count    = 4,
    parameter int unsigned timeout_limit = 4 * countlimit
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        mon_en,
    input  logic        clkmon_in,
    output logic        rise_pulse,
    output logic        fall_pulse,
    output logic [31:0] half_period,
    output logic        locked,
    output logic        lost,
    output logic [7:0]  err_count
`ifdef CLKMON_DUTY_EN
    ,
    output logic [31:0] high_period,
    output logic [31:0] low_period,
    output logic        duty_err
`endif
);

    localparam int unsigned lo_lim = (countlimit > tol) ? countlimit - tol : 32'd0;
    localparam int unsigned hi_lim = countlimit + tol;

    typedef enum logic [1:0] {st_idle, st_acq, st_locked, st_lost} state_t;

    state_t      state, next_state;
    logic        s1, s2, s3;
    logic [31:0] hcnt;
    logic [7:0]  gcnt, next_gcnt;
    logic [31:0] gcnt_inc;
    logic        edge_cyc, good, timeout, take_meas, err_inc;

    assign edge_cyc = s2 ^ s3;
    assign good     = edge_cyc && (hcnt >= lo_lim) && (hcnt <= hi_lim);
    assign timeout  = hcnt >= timeout_limit;
    assign gcnt_inc = 32'(gcnt) + 32'd1;

    // s1 is the metastability stage; only s2/s3 feed logic.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= clkmon_in;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= s2 & ~s3 & mon_en;
            fall_pulse <= ~s2 & s3 & mon_en;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
        end else if (!mon_en) begin
            hcnt <= '0;
        end else if (edge_cyc) begin
            hcnt <= 32'd1;
        end else if (hcnt != '1) begin
            hcnt <= hcnt + 32'd1;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state       <= st_idle;
            gcnt        <= '0;
            half_period <= '0;
            err_count   <= '0;
        end else begin
            state <= next_state;
            gcnt  <= next_gcnt;
            if (take_meas) begin
                half_period <= hcnt;
            end
            if (err_inc && err_count != 8'hff) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // An edge always takes priority over a coincident timeout.
    always_comb begin
        next_state = state;
        next_gcnt  = gcnt;
        take_meas  = 1'b0;
        err_inc    = 1'b0;
        if (!mon_en) begin
            next_state = st_idle;
            next_gcnt  = '0;
        end else begin
            case (state)
                st_idle: begin
                    if (edge_cyc) begin
                        next_state = st_acq;
                        next_gcnt  = '0;
                    end
                end
                st_acq: begin
                    if (edge_cyc) begin
                        take_meas = 1'b1;
                        if (!good) begin
                            next_gcnt = '0;
                        end else if (gcnt_inc >= lock_count) begin
                            next_state = st_locked;
                            next_gcnt  = '0;
                        end else begin
                            next_gcnt = gcnt_inc[7:0];
                        end
                    end else if (timeout) begin
                        next_state = st_lost;
                        next_gcnt  = '0;
                    end
                end
                st_locked: begin
                    if (edge_cyc) begin
                        take_meas = 1'b1;
                        if (!good) begin
                            next_state = st_acq;
                            next_gcnt  = '0;
                            err_inc    = 1'b1;
                        end
                    end else if (timeout) begin
                        next_state = st_lost;
                        err_inc    = 1'b1;
                    end
                end
                st_lost: begin
                    if (edge_cyc) begin
                        next_state = st_acq;
                        next_gcnt  = '0;
                    end
                end
                default: begin
                    next_state = st_idle;
                    next_gcnt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked = (state == st_locked);
        lost   = (state == st_lost);
    end

`ifdef CLKMON_DUTY_EN
    logic [31:0] high_nxt, low_nxt, duty_diff;

    // A rising edge ends a low phase; a falling edge ends a high phase.
    always_comb begin
        high_nxt = high_period;
        low_nxt  = low_period;
        if (mon_en && edge_cyc) begin
            if (s2) begin
                low_nxt = hcnt;
            end else begin
                high_nxt = hcnt;
            end
        end
        duty_diff = (high_nxt > low_nxt) ? high_nxt - low_nxt : low_nxt - high_nxt;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            high_period <= '0;
            low_period  <= '0;
            duty_err    <= 1'b0;
        end else begin
            high_period <= high_nxt;
            low_period  <= low_nxt;
            if (!mon_en || state == st_idle || state == st_lost) begin
                duty_err <= 1'b0;
            end else if (edge_cyc) begin
                duty_err <= (duty_diff > tol);
            end
        end
    end
`endif

endmodule
